// File: rtl/bvashr_inv_search.sv
// Sequential inverse search for arithmetic right shift: finds the smallest x
// with (x >>a s) == t (op=0) or (s >>a x) == t (op=1), one candidate per cycle.
module bvashr_inv_search #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         found,
  output logic [W-1:0] x
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [W-1:0] K_LAST = {W{1'b1}};

  state_e       state_q, state_d;
  logic         op_q, op_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] t_q, t_d;
  logic [W-1:0] k_q, k_d;
  logic         found_q, found_d;
  logic [W-1:0] x_q, x_d;
  logic         busy_q, busy_d;
  logic         res_valid_q, res_valid_d;
  logic [W-1:0] shifted;
  logic         match;

  // Shift amounts of W or more saturate to a full sign fill.
  function automatic logic [W-1:0] ashr(input logic [W-1:0] val,
                                        input logic [W-1:0] amt);
    if (32'(amt) >= W) return {W{val[W-1]}};
    return W'($signed(val) >>> amt);
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    s_d         = s_q;
    t_d         = t_q;
    k_d         = k_q;
    found_d     = found_q;
    x_d         = x_q;
    shifted     = op_q ? ashr(s_q, k_q) : ashr(k_q, s_q);
    match       = (shifted == t_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          s_d     = s;
          t_d     = t;
          k_d     = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (match) begin
          found_d = 1'b1;
          x_d     = k_q;
          state_d = S_DONE;
        end else if (k_q == K_LAST) begin
          found_d = 1'b0;
          x_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + W'(1);
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d == S_SEARCH);
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      s_q         <= '0;
      t_q         <= '0;
      k_q         <= '0;
      found_q     <= 1'b0;
      x_q         <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      s_q         <= s_d;
      t_q         <= t_d;
      k_q         <= k_d;
      found_q     <= found_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign found     = found_q;
  assign x         = x_q;

endmodule

// File: tb/tb_bvashr_inv_search.sv
// Directed bench for bvashr_inv_search: hand-computed searches, back-pressure
// in DONE, start/handshake collision and mid-search reset.
module tb_bvashr_inv_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       op;
  logic [3:0] s;
  logic [3:0] t;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic       found;
  logic [3:0] x;

  int checks = 0;
  int errors = 0;

  bvashr_inv_search #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .s         (s),
    .t         (t),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .found     (found),
    .x         (x)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a search, wait for res_valid, check result and latency, then handshake.
  task automatic run_search(input string tag, input logic o, input logic [3:0] sv,
                            input logic [3:0] tv, input logic ef, input logic [3:0] ex,
                            input int elat);
    int lat;
    op = o; s = sv; t = tv; start = 1'b1; res_ready = 1'b0;
    step();
    start = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!res_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_found"}, 32'(found), 32'(ef));
    check({tag, "_x"}, 32'(x), 32'(ex));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; op = 1'b0; s = '0; t = '0; res_ready = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    rst = 1'b0;
    step();

    run_search("neg_s_op1", 1'b1, 4'b1000, 4'b1110, 1'b1, 4'b0010, 4);
    run_search("nomatch", 1'b1, 4'b0101, 4'b1000, 1'b0, 4'b0000, 17);
    run_search("op0_min", 1'b0, 4'b0001, 4'b1100, 1'b1, 4'b1000, 10);
    run_search("pos_to_zero", 1'b1, 4'b0111, 4'b0000, 1'b1, 4'b0011, 5);
    run_search("op0_noshift", 1'b0, 4'b0000, 4'b0101, 1'b1, 4'b0101, 7);
    run_search("op0_sat", 1'b0, 4'b0100, 4'b1111, 1'b1, 4'b1000, 10);
    run_search("op0_sat_zero", 1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2);

    // Back-pressure in DONE with start pulsing and operands changing.
    op = 1'b0; s = 4'b0001; t = 4'b1100; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      step();
      lat++;
    end
    check("hold_lat", 32'(lat), 32'd10);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; op = 1'b1; s = 4'(i + 3); t = 4'(i);
      step();
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_found", 32'(found), 32'd1);
      check("hold_x", 32'(x), 32'd8);
      check("hold_busy", 32'(busy), 32'd0);
    end

    // Start during the handshake cycle is ignored, then taken in IDLE.
    op = 1'b1; s = 4'b1000; t = 4'b1110; start = 1'b1; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("hs_valid", 32'(res_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_prev_x", 32'(x), 32'd8);
    check("acc_prev_found", 32'(found), 32'd1);
    lat = 1;
    while (!res_valid && lat < 40) begin
      step();
      lat++;
    end
    check("acc_lat", 32'(lat), 32'd4);
    check("acc_x", 32'(x), 32'd2);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset in the middle of a no-match search.
    op = 1'b1; s = 4'b0101; t = 4'b1000; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; start = 1'b1; res_ready = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; res_ready = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(res_valid), 32'd0);
    check("mrst_found", 32'(found), 32'd0);
    check("mrst_x", 32'(x), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("mrst_quiet", 32'({busy, res_valid}), 32'd0);
    end
    run_search("after_rst", 1'b0, 4'b0001, 4'b1100, 1'b1, 4'b1000, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bvashr_inv_search.md
BVASHR_INV_SEARCH -- requirements
Module: bvashr_inv_search

Interface
REQ-001 SHALL have parameter W, default 4, which is the bit width of s, t and x; the search space is 0..2^W-1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new search; accepted only when in IDLE.
REQ-005 SHALL have port op, input, 1 bit: problem select. 0 means find x with (x >>a s) == t. 1 means find x with (s >>a x) == t.
REQ-006 SHALL have port s, input, W bits: fixed operand, two's complement.
REQ-007 SHALL have port t, input, W bits: target value.
REQ-008 SHALL have port busy, output, 1 bit: high while a search is in progress (SEARCH state).
REQ-009 SHALL have port res_valid, output, 1 bit: result available (DONE state).
REQ-010 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port found, output, 1 bit: a satisfying x exists.
REQ-012 SHALL have port x, output, W bits: the smallest satisfying x, or 0 when found=0.

Function
REQ-013 SHALL implement three states: IDLE, SEARCH, DONE.
REQ-014 SHALL behave as follows in IDLE with start=1: latch op, s and t into registers; clear the candidate counter k to 0; go to SEARCH. Inputs SHALL be sampled only on this cycle.
REQ-015 SHALL evaluate one candidate per cycle in SEARCH. Candidate k is evaluated in cycle N+1+k, where N is the accept cycle.
REQ-016 SHALL compute the arithmetic shift at W bits with sign fill. A shift amount of W or more SHALL yield all bits equal to the sign bit of the shifted operand.
REQ-017 SHALL handle a match at candidate k as follows: on the next edge, found<=1, x<=k, go to DONE. Candidates above k SHALL NOT be evaluated, so the smallest x is returned.
REQ-018 SHALL handle no match at k=2^W-1 as follows: found<=0, x<=0, go to DONE. The counter SHALL NOT wrap back to 0.
REQ-019 SHALL otherwise increment k by 1 and remain in SEARCH.
REQ-020 SHALL assert res_valid in DONE. Latency from the accept cycle to res_valid is k+2 cycles; the worst case (no match) is 2^W+1 cycles, i.e. 17 for W=4.
REQ-021 SHALL hold found and x stable in DONE until the cycle in which res_valid and res_ready are both 1; on that edge the state goes to IDLE.
REQ-022 SHALL ignore start while in SEARCH or DONE. start in the same cycle as a DONE handshake SHALL be ignored; it is accepted in the following IDLE cycle.
REQ-023 SHALL keep the result of the previous search on found and x while in IDLE and SEARCH. These outputs are qualified only by res_valid.
REQ-024 SHALL be free of combinational paths from any input to any output.

Reset
REQ-025 SHALL on rst=1 at an edge force state IDLE, busy=0, res_valid=0, found=0, x=0, k=0, regardless of state.
REQ-026 SHALL give rst priority over start and res_ready in the same cycle. A search in progress SHALL be abandoned with no res_valid pulse.

Verification
REQ-027 SHALL cover: op=1, s=1000, t=1110 -> found=1, x=0010, res_valid at N+4.
REQ-028 SHALL cover: op=1, s=0101, t=1000 (no solution) -> found=0, x=0000, res_valid at N+17.
REQ-029 SHALL cover: op=0, s=0001, t=1100 -> found=1, x=1000 (smallest of 1000 and 1001), res_valid at N+10.
REQ-030 SHALL cover: op=1, s=0111, t=0000 -> x=0011. This checks that shifts of 4 or more are not reached once a match exists.
REQ-031 SHALL cover: res_ready held at 0 for 5 cycles in DONE with start pulsed and s/t changed -> found, x and res_valid stable; no new search begins until after the handshake.
REQ-032 SHALL cover: rst asserted at N+5 of a no-match search -> next cycle IDLE, all outputs 0; a new start then completes normally.
